key_debounce_array: RTL and testbench
=====================================

Name: key_debounce_array

Overview:
- N-channel input conditioner for the board push-buttons and switches; the next generation of the single-key debouncer.
- Per channel: 2-flop synchroniser, debounce counter, press/release edge pulses, and a hold-to-repeat pulse train for menu and test-mover stepping.
- Also reports which key was pressed most recently, for Pac-Man direction buffering.
- Sits between the raw KEY/SW pins and the game/test controllers, in the 50 MHz domain.

Parameters:
- N_KEYS, 4, number of channels (1..16).
- ACTIVE_LOW, 1, 1 = raw input reads 0 when pressed (DE2-115 KEY); 0 = active-high (SW).
- DEBOUNCE_CYCLES, 500000, consecutive cycles a new sync level must persist before it is accepted (10 ms at 50 MHz); minimum 1.
- REPEAT_DELAY, 25000000, cycles from press to first o_repeat pulse; 0 disables repeat.
- REPEAT_PERIOD, 5000000, cycles between later o_repeat pulses; minimum 1.

Ports:
- i_clk  in  1  50 MHz system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_keys  in  N_KEYS  raw asynchronous inputs.
- i_enable  in  1  1 = pulses allowed; 0 = pulse outputs suppressed.
- o_level  out  N_KEYS  debounced pressed state, 1 = pressed.
- o_press  out  N_KEYS  1-cycle pulse on accepted press.
- o_release  out  N_KEYS  1-cycle pulse on accepted release.
- o_repeat  out  N_KEYS  1-cycle auto-repeat pulses while held.
- o_any  out  1  OR of o_level.
- o_last_key  out  $clog2(N_KEYS) (min 1)  index of the most recent press.
- o_last_valid  out  1  1 once any press has been accepted since reset.

Behaviour:
- One clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- During reset:
  - All outputs are 0.
  - Synchroniser flops load the inactive raw level: 1 if ACTIVE_LOW, else 0.
  - All counters clear.
- Polarity: pressed = sync2 XOR ACTIVE_LOW.
- Debounce (per channel):
  - CW = $clog2(DEBOUNCE_CYCLES+1).
  - pressed == o_level: counter clears to 0.
  - pressed != o_level: counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 in a mismatch cycle, o_level toggles on the next edge and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES leaves o_level unchanged.
  - Latency from raw edge to o_level = DEBOUNCE_CYCLES+2 cycles.
- Edges:
  - o_press and o_release are registered and assert in the same cycle o_level changes, for exactly 1 cycle.
  - They are gated by i_enable sampled in that cycle.
- Repeat (per channel):
  - A counter runs only while o_level=1 and REPEAT_DELAY>0. It clears on the press cycle.
  - First o_repeat pulse: REPEAT_DELAY cycles after the o_press cycle.
  - Subsequent pulses: every REPEAT_PERIOD cycles.
  - The counter saturates/wraps inside the period window and never overflows.
  - Release clears the counter the same cycle o_level falls; no repeat pulse is issued in that cycle.
  - i_enable=0 forces o_repeat=0 and holds the counter at 0. Re-enabling while held restarts the REPEAT_DELAY window.
- Last key:
  - On any accepted press (whether or not i_enable is high), o_last_key takes that index and o_last_valid sets.
  - If several channels are accepted in the same cycle, the lowest index wins.
  - Releases do not change o_last_key.
- o_any: registered OR of the next o_level values, aligned with o_level.
- Reset asserted mid-count or mid-hold: everything returns to reset values. No pulse is emitted on reset release, even if a key is held. A held key is reported as a press DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- Channels are fully independent apart from the o_last_key priority.

Decomposition:
- Package key_pkg:
  - function clog2_min1.
  - Default timing constants: DEBOUNCE_10MS=500000, REPEAT_500MS=25000000, REPEAT_100MS=5000000 at 50 MHz.
  - Key index constants for the direction buttons: K_RIGHT=0, K_DOWN=1, K_UP=2, K_LEFT=3.
- Sub-module key_debounce_channel (sync, debounce, edge, repeat for one input), instantiated N_KEYS times in a generate loop.
- Top level holds only the o_any OR and the o_last_key priority encoder.

Test Plan (N_KEYS=4, ACTIVE_LOW=1, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
1. Hold i_rst_n=0 with i_keys=4'b0000 (all pressed), then release reset at cycle 0 -> all outputs 0 during reset. At cycle 6: o_level=4'b1111, o_press=4'b1111 for 1 cycle, o_last_key=0, o_last_valid=1.
2. i_keys[2] low for 3 cycles then high -> o_level[2] stays 0, with no pulses. Held low instead -> o_level[2]=1 and o_press[2]=1 exactly 6 cycles after the raw edge.
3. Hold key 1 -> o_repeat[1] pulses at press+10, +13, +16. Release -> o_release[1] pulses and no further o_repeat appears.
4. Keys 3 and 1 pressed on the same raw edge -> o_last_key=1. Then press key 3 alone -> o_last_key=3. Release key 3 -> o_last_key stays 3.
5. i_enable=0 during a press -> o_level rises, o_press=0, o_repeat=0, o_last_key updates. Raise i_enable while still held -> first o_repeat comes 10 cycles later.
6. Assert i_rst_n=0 asynchronously mid-debounce (counter=2) and mid-repeat -> outputs go to 0 immediately, without waiting for a clock edge. No spurious pulses appear after reset is released.

Source files
------------

// File: rtl/key_debounce_array_pkg.sv
// Shared timing defaults, direction-key indices and width helper for the
// key debounce array and its per-channel conditioner.
package key_pkg;

    localparam int DEBOUNCE_10MS = 500000;
    localparam int REPEAT_500MS  = 25000000;
    localparam int REPEAT_100MS  = 5000000;

    localparam int K_RIGHT = 0;
    localparam int K_DOWN  = 1;
    localparam int K_UP    = 2;
    localparam int K_LEFT  = 3;

    // $clog2 that never yields a zero-width vector.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One input conditioner: 2-flop synchroniser, debounce counter, gated
// press/release pulses and a hold-to-repeat pulse train.
module key_debounce_channel
    import key_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int REPEAT_DELAY    = REPEAT_500MS,
    parameter int REPEAT_PERIOD   = REPEAT_100MS
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    input  logic i_enable,
    output logic o_level,
    output logic o_level_next,
    output logic o_accept_press,
    output logic o_press,
    output logic o_release,
    output logic o_repeat
);

    localparam int            CW      = clog2_min1(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          mismatch, accept;

    always_comb begin
        mismatch  = (sync2_q ^ ACTIVE_LOW) != level_q;
        accept    = mismatch && (db_cnt_q == DB_LAST);
        db_cnt_d  = (mismatch && !accept) ? db_cnt_q + CW'(1) : '0;
        level_d   = level_q ^ accept;
        press_d   = accept && !level_q && i_enable;
        release_d = accept && level_q && i_enable;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q   <= ACTIVE_LOW;
            sync2_q   <= ACTIVE_LOW;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= i_key;
            sync2_q   <= sync1_q;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    if (REPEAT_DELAY > 0) begin : g_rpt
        localparam int            RW        = clog2_min1(REPEAT_DELAY + REPEAT_PERIOD);
        localparam logic [RW-1:0] FIRST_HIT = RW'(REPEAT_DELAY - 1);
        localparam logic [RW-1:0] WRAP_HIT  = RW'(REPEAT_DELAY + REPEAT_PERIOD - 1);
        localparam logic [RW-1:0] WRAP_TO   = RW'(REPEAT_DELAY);

        logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
        logic          rpt_q, rpt_d;

        // Counter only advances on steady, enabled holds; after the first
        // pulse it cycles inside [REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD).
        always_comb begin
            rpt_cnt_d = '0;
            rpt_d     = 1'b0;
            if (level_q && level_d && i_enable) begin
                rpt_d     = (rpt_cnt_q == FIRST_HIT) || (rpt_cnt_q == WRAP_HIT);
                rpt_cnt_d = (rpt_cnt_q == WRAP_HIT) ? WRAP_TO : rpt_cnt_q + RW'(1);
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                rpt_cnt_q <= '0;
                rpt_q     <= 1'b0;
            end else begin
                rpt_cnt_q <= rpt_cnt_d;
                rpt_q     <= rpt_d;
            end
        end

        assign o_repeat = rpt_q;
    end else begin : g_no_rpt
        assign o_repeat = 1'b0;
    end

    assign o_level        = level_q;
    assign o_level_next   = level_d;
    assign o_accept_press = accept && !level_q;
    assign o_press        = press_q;
    assign o_release      = release_q;

endmodule

// File: rtl/key_debounce_array.sv
// N-channel push-button/switch conditioner with an any-pressed flag and a
// most-recent-press index (lowest channel wins on simultaneous presses).
module key_debounce_array
    import key_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int REPEAT_DELAY    = REPEAT_500MS,
    parameter int REPEAT_PERIOD   = REPEAT_100MS
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [N_KEYS-1:0]                   i_keys,
    input  logic                                i_enable,
    output logic [N_KEYS-1:0]                   o_level,
    output logic [N_KEYS-1:0]                   o_press,
    output logic [N_KEYS-1:0]                   o_release,
    output logic [N_KEYS-1:0]                   o_repeat,
    output logic                                o_any,
    output logic [clog2_min1(N_KEYS)-1:0]       o_last_key,
    output logic                                o_last_valid
);

    localparam int LW = clog2_min1(N_KEYS);

    logic [N_KEYS-1:0] level_next;
    logic [N_KEYS-1:0] accept_press;
    logic              any_q, any_d;
    logic [LW-1:0]     last_q, last_d;
    logic              valid_q, valid_d;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
        key_debounce_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .i_clk          (i_clk),
            .i_rst_n        (i_rst_n),
            .i_key          (i_keys[g]),
            .i_enable       (i_enable),
            .o_level        (o_level[g]),
            .o_level_next   (level_next[g]),
            .o_accept_press (accept_press[g]),
            .o_press        (o_press[g]),
            .o_release      (o_release[g]),
            .o_repeat       (o_repeat[g])
        );
    end

    // Presses are tracked regardless of i_enable; scanning downward lets the
    // lowest index overwrite any higher one accepted in the same cycle.
    always_comb begin
        any_d   = |level_next;
        last_d  = last_q;
        valid_d = valid_q;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (accept_press[i]) begin
                last_d  = LW'(i);
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            any_q   <= 1'b0;
            last_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            any_q   <= any_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign o_any        = any_q;
    assign o_last_key   = last_q;
    assign o_last_valid = valid_q;

endmodule

// File: tb/tb_key_debounce_array.sv
// Self-checking bench for key_debounce_array with a window-based reference
// model (debounce as "last DEBOUNCE synchronised samples all disagree").
module tb_key_debounce_array;

    localparam int N  = 4;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] keys  = '1;
    logic         en    = 1'b1;

    logic [N-1:0] o_level, o_press, o_release, o_repeat;
    logic         o_any;
    logic [1:0]   o_last_key;
    logic         o_last_valid;

    int vectors     = 0;
    int miscompares = 0;

    key_debounce_array #(
        .N_KEYS          (N),
        .ACTIVE_LOW      (1'b1),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_keys       (keys),
        .i_enable     (en),
        .o_level      (o_level),
        .o_press      (o_press),
        .o_release    (o_release),
        .o_repeat     (o_repeat),
        .o_any        (o_any),
        .o_last_key   (o_last_key),
        .o_last_valid (o_last_valid)
    );

    always #5 clk = ~clk;

    // Reference model: hist[k] holds the pressed value sampled k edges ago.
    logic [N-1:0] hist [DB+2];
    int           hold [N];
    logic [N-1:0] m_level = '0, m_press = '0, m_release = '0, m_repeat = '0;
    logic [N-1:0] m_next, m_acc;
    logic         m_any = 1'b0, m_valid = 1'b0, flip;
    logic [1:0]   m_last = 2'd0;

    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            for (int k = 0; k < DB + 2; k++) hist[k] = '0;
            for (int i = 0; i < N; i++) hold[i] = 0;
            m_level = '0; m_press = '0; m_release = '0; m_repeat = '0;
            m_any = 1'b0; m_valid = 1'b0; m_last = 2'd0;
        end else begin
            for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = ~keys;
            m_next = m_level;
            for (int i = 0; i < N; i++) begin
                flip = 1'b1;
                for (int k = 2; k <= DB + 1; k++)
                    if (hist[k][i] == m_level[i]) flip = 1'b0;
                if (flip) m_next[i] = ~m_level[i];
            end
            m_acc     = m_next & ~m_level;
            m_press   = m_acc & {N{en}};
            m_release = ~m_next & m_level & {N{en}};
            for (int i = 0; i < N; i++) begin
                if (m_level[i] && m_next[i] && en) begin
                    hold[i]++;
                    m_repeat[i] = (hold[i] == RD) || (hold[i] > RD && ((hold[i] - RD) % RP) == 0);
                end else begin
                    hold[i]     = 0;
                    m_repeat[i] = 1'b0;
                end
            end
            for (int i = N - 1; i >= 0; i--)
                if (m_acc[i]) begin m_last = 2'(i); m_valid = 1'b1; end
            m_level = m_next;
            m_any   = |m_next;
        end
    end

    logic [19:0] dut_v, mdl_v;
    assign dut_v = {o_level, o_press, o_release, o_repeat, o_any, o_last_key, o_last_valid};
    assign mdl_v = {m_level, m_press, m_release, m_repeat, m_any, m_last, m_valid};

    task automatic test_reset();
        rst_n = 1'b0; keys = '0; en = 1'b1;
        repeat (3) @(posedge clk);
        #1; vectors++;
        if (dut_v !== '0) begin miscompares++; $display("FAIL reset_state: got %h expected %h", dut_v, 20'h0); end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1; vectors++;
            if (dut_v !== mdl_v) begin miscompares++; $display("FAIL reset_release_model c=%0d: got %h expected %h", c, dut_v, mdl_v); end
            if (c == 5) begin
                vectors++;
                if ({o_level, o_press} !== 8'h00) begin miscompares++; $display("FAIL reset_early_press: got %h expected 00", {o_level, o_press}); end
            end
            if (c == 6) begin
                vectors++;
                if ({o_level, o_press, o_last_key, o_last_valid} !== {4'hF, 4'hF, 2'd0, 1'b1}) begin
                    miscompares++; $display("FAIL reset_held_press: got %h expected %h", {o_level, o_press, o_last_key, o_last_valid}, {4'hF, 4'hF, 2'd0, 1'b1});
                end
            end
            if (c == 7) begin
                vectors++;
                if (o_press !== 4'h0) begin miscompares++; $display("FAIL reset_press_width: got %h expected 0", o_press); end
            end
        end
        @(negedge clk); keys = '1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1; vectors++;
            if (dut_v !== mdl_v) begin miscompares++; $display("FAIL reset_drain_model: got %h expected %h", dut_v, mdl_v); end
        end
    endtask

    task automatic test_glitch();
        @(negedge clk); keys[2] = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1; vectors++;
            if (dut_v !== mdl_v) begin miscompares++; $display("FAIL glitch_model: got %h expected %h", dut_v, mdl_v); end
        end
        @(negedge clk); keys[2] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1; vectors++;
            if ({o_level[2], o_press[2], o_release[2]} !== 3'b000) begin
                miscompares++; $display("FAIL glitch_ignored: got %b expected 000", {o_level[2], o_press[2], o_release[2]});
            end
        end
        @(negedge clk); keys[2] = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1; vectors++;
            if (dut_v !== mdl_v) begin miscompares++; $display("FAIL press_model: got %h expected %h", dut_v, mdl_v); end
            if (c == 5) begin
                vectors++;
                if (o_level[2] !== 1'b0) begin miscompares++; $display("FAIL press_too_early: got %b expected 0", o_level[2]); end
            end
            if (c == 6) begin
                vectors++;
                if ({o_level[2], o_press[2]} !== 2'b11) begin miscompares++; $display("FAIL press_latency: got %b expected 11", {o_level[2], o_press[2]}); end
            end
        end
        @(negedge clk); keys[2] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1; vectors++;
            if (dut_v !== mdl_v) begin miscompares++; $display("FAIL glitch_drain_model: got %h expected %h", dut_v, mdl_v); end
        end
    endtask

    task automatic test_repeat();
        logic found;
        logic exp;
        found = 1'b0;
        @(negedge clk); keys[1] = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk); #1; vectors++;
            if (dut_v !== mdl_v) begin miscompares++; $display("FAIL repeat_press_model: got %h expected %h", dut_v, mdl_v); end
            if (o_press[1]) found = 1'b1;
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL repeat_press_timeout: got 0 expected 1"); end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1; vectors++;
            exp = (k == 10) || (k == 13) || (k == 16) || (k == 19);
            if (o_repeat[1] !== exp) begin miscompares++; $display("FAIL repeat_timing k=%0d: got %b expected %b", k, o_repeat[1], exp); end
        end
        @(negedge clk); keys[1] = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            @(posedge clk); #1; vectors++;
            if (dut_v !== mdl_v) begin miscompares++; $display("FAIL release_model: got %h expected %h", dut_v, mdl_v); end
            if (o_release[1]) found = 1'b1;
        end
        vectors++;
        if (!found) begin miscompares++; $display("FAIL release_timeout: got 0 expected 1"); end
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1; vectors++;
            if ({o_repeat, o_level} !== 8'h00) begin miscompares++; $display("FAIL repeat_after_release: got %h expected 00", {o_repeat, o_level}); end
        end
    endtask

    task automatic test_last_key();
        logic [3:0] pat [4];
        logic [1:0] want [4];
        pat[0] = 4'b0101; want[0] = 2'd1;
        pat[1] = 4'b1111; want[1] = 2'd1;
        pat[2] = 4'b0111; want[2] = 2'd3;
        pat[3] = 4'b1111; want[3] = 2'd3;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk); keys = pat[p];
            for (int c = 0; c < 8; c++) begin
                @(posedge clk); #1; vectors++;
                if (dut_v !== mdl_v) begin miscompares++; $display("FAIL last_key_model p=%0d: got %h expected %h", p, dut_v, mdl_v); end
            end
            vectors++;
            if ({o_last_key, o_last_valid} !== {want[p], 1'b1}) begin
                miscompares++; $display("FAIL last_key p=%0d: got %0d/%b expected %0d/1", p, o_last_key, o_last_valid, want[p]);
            end
        end
    endtask

    task automatic test_enable();
        logic exp;
        @(negedge clk); en = 1'b0; keys = 4'b1110;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1; vectors++;
            if ({o_press, o_repeat} !== 8'h00) begin miscompares++; $display("FAIL enable_gating c=%0d: got %h expected 00", c, {o_press, o_repeat}); end
        end
        vectors++;
        if ({o_level, o_last_key} !== {4'b0001, 2'd0}) begin
            miscompares++; $display("FAIL enable_level_last: got %h expected %h", {o_level, o_last_key}, {4'b0001, 2'd0});
        end
        @(negedge clk); en = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            @(posedge clk); #1; vectors++;
            exp = (j == 10) || (j == 13);
            if (o_repeat[0] !== exp) begin miscompares++; $display("FAIL reenable_repeat j=%0d: got %b expected %b", j, o_repeat[0], exp); end
        end
        @(negedge clk); keys = '1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1; vectors++;
            if (dut_v !== mdl_v) begin miscompares++; $display("FAIL enable_drain_model: got %h expected %h", dut_v, mdl_v); end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); keys = 4'b1101;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1; vectors++;
            if (dut_v !== mdl_v) begin miscompares++; $display("FAIL hold_model: got %h expected %h", dut_v, mdl_v); end
        end
        vectors++;
        if (o_level !== 4'b0010) begin miscompares++; $display("FAIL pre_reset_level: got %b expected 0010", o_level); end
        #2; rst_n = 1'b0; #1; vectors++;
        if (dut_v !== '0) begin miscompares++; $display("FAIL async_reset_repeat: got %h expected %h", dut_v, 20'h0); end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1; vectors++;
            if (dut_v !== mdl_v) begin miscompares++; $display("FAIL post_reset_model c=%0d: got %h expected %h", c, dut_v, mdl_v); end
            if (c < 6) begin
                vectors++;
                if ({o_press, o_level} !== 8'h00) begin miscompares++; $display("FAIL spurious_pulse c=%0d: got %h expected 00", c, {o_press, o_level}); end
            end
        end
        @(negedge clk); keys = 4'b1001;
        repeat (4) @(posedge clk);
        #2; rst_n = 1'b0; #1; vectors++;
        if (dut_v !== '0) begin miscompares++; $display("FAIL async_reset_debounce: got %h expected %h", dut_v, 20'h0); end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1; vectors++;
            if (dut_v !== mdl_v) begin miscompares++; $display("FAIL restart_model c=%0d: got %h expected %h", c, dut_v, mdl_v); end
            if (c == 5) begin
                vectors++;
                if (o_level !== 4'b0000) begin miscompares++; $display("FAIL restart_early: got %b expected 0000", o_level); end
            end
            if (c == 6) begin
                vectors++;
                if ({o_press, o_last_key} !== {4'b0110, 2'd1}) begin
                    miscompares++; $display("FAIL restart_press: got %h expected %h", {o_press, o_last_key}, {4'b0110, 2'd1});
                end
            end
        end
        @(negedge clk); keys = '1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1; vectors++;
            if (dut_v !== mdl_v) begin miscompares++; $display("FAIL reset_drain_model2: got %h expected %h", dut_v, mdl_v); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 6 + 12 * i) == 0) keys[i] = ~keys[i];
            if ($urandom_range(0, 59) == 0) en = ~en;
            @(posedge clk); #1; vectors++;
            if (dut_v !== mdl_v) begin miscompares++; $display("FAIL random_model c=%0d: got %h expected %h", c, dut_v, mdl_v); end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_repeat();
        test_last_key();
        test_enable();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
